// File: rtl/hq2x_scanout.sv
// hq2x_scanout: display timing, line-buffer read and lock FSM for the 2x upscaler output.
// Define SCANOUT_SCANLINE_EN to halve every channel on odd output rows.
module hq2x_scanout #(
    parameter int H_ACTIVE = 512,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 64,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_available,
    input  logic [14:0] pixel_in,
    output logic [9:0]  read_x,
    output logic        line_req,
    output logic        frame_req,
    output logic        locked,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [14:0] rgb
);
    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] HS_B   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_E   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] VA     = 10'(V_ACTIVE);
    localparam logic [9:0] VS_B   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_E   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    typedef enum logic {SYNC_WAIT, RUN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic        flag_q, flag_d;
    logic        active1_q, active1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [14:0] rgb_q, rgb_d, pix;
    logic        active0, frame_start;

`ifdef SCANOUT_SCANLINE_EN
    logic v1_q, v1_d;
    always_comb begin
        v1_d = v_q[0];
        pix  = v1_q ? {1'b0, pixel_in[14:11], 1'b0, pixel_in[9:6], 1'b0, pixel_in[4:1]} : pixel_in;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) v1_q <= 1'b0;
        else          v1_q <= v1_d;
    end
`else
    always_comb pix = pixel_in;
`endif

    always_comb begin
        h_d         = (h_q == H_LAST) ? '0 : h_q + 10'd1;
        v_d         = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
        active0     = (h_q < HA) && (v_q < VA);
        frame_start = (h_q == '0) && (v_q == '0);
        read_x      = active0 ? {v_q[0], h_q[8:0]} : '0;
        line_req    = (h_q == HA) && v_q[0] && (v_q < VA);
        frame_req   = (h_q == '0) && (v_q == VA);
        locked      = (state_q == RUN);
        // a frame only starts once the upscaler signalled readiness during vblank
        state_d     = (state_q == SYNC_WAIT && frame_start && flag_q) ? RUN : state_q;
        flag_d      = (state_q == SYNC_WAIT) && !frame_start && (flag_q || (frame_available && v_q >= VA));
        active1_d   = active0;
        hs1_d       = !((h_q >= HS_B) && (h_q < HS_E));
        vs1_d       = !((v_q >= VS_B) && (v_q < VS_E));
        de_d        = active1_q;
        hsync_d     = hs1_q;
        vsync_d     = vs1_q;
        rgb_d       = (active1_q && state_q == RUN) ? pix : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_q       <= '0;
            v_q       <= '0;
            state_q   <= SYNC_WAIT;
            flag_q    <= 1'b0;
            active1_q <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            de_q      <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_q     <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            state_q   <= state_d;
            flag_q    <= flag_d;
            active1_q <= active1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de_q      <= de_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
        end
    end

    assign de    = de_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign rgb   = rgb_q;
endmodule
